// File: rtl/sqrt_checker.sv
// Verifies a candidate integer square root: squares the root with an 8-step
// shift-add multiplier, then checks root^2 <= radicand < (root+1)^2.
module sqrt_checker (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  radicand,
    input  logic [7:0]  root,
    output logic [15:0] square,
    output logic        pass,
    output logic        valid_bit,
    output logic        busy,
    output logic [1:0]  state_dbg_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  rad_q, rad_d;
    logic [7:0]  root_q, root_d;
    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [15:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] square_q, square_d;
    logic        pass_q, pass_d;
    logic        valid_q, valid_d;
    logic [16:0] upper;

    // (root+1)^2 = root^2 + 2*root + 1; 17 bits since 256^2 does not fit in 16.
    assign upper = {1'b0, acc_q} + {8'b0, root_q, 1'b0} + 17'd1;

    // Start protocol: enable is a one-cycle pulse with no ready signal. It is
    // accepted only in IDLE or DONE; pulses arriving while busy are dropped.
    always_comb begin
        state_d  = state_q;
        rad_d    = rad_q;
        root_d   = root_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        square_d = square_q;
        pass_d   = pass_q;
        valid_d  = valid_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (enable) begin
                    rad_d    = radicand;
                    root_d   = root;
                    mcand_d  = {8'b0, root};
                    mplier_d = root;
                    acc_d    = 16'd0;
                    cnt_d    = 4'd0;
                    valid_d  = 1'b0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                // Fixed 8 iterations regardless of data; 255^2 fits in 16 bits.
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                square_d = acc_q;
                pass_d   = (acc_q <= {8'b0, rad_q}) && (upper > {9'b0, rad_q});
                valid_d  = 1'b1;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            rad_q    <= 8'd0;
            root_q   <= 8'd0;
            mcand_q  <= 16'd0;
            mplier_q <= 8'd0;
            acc_q    <= 16'd0;
            cnt_q    <= 4'd0;
            square_q <= 16'd0;
            pass_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rad_q    <= rad_d;
            root_q   <= root_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            square_q <= square_d;
            pass_q   <= pass_d;
            valid_q  <= valid_d;
        end
    end

    assign square      = square_q;
    assign pass        = pass_q;
    assign valid_bit   = valid_q;
    assign busy        = (state_q == S_CALC) || (state_q == S_CHECK);
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_sqrt_checker.sv
// Directed bench for sqrt_checker: latency, boundaries, ignored pulses,
// asynchronous reset and a full radicand sweep.
module tb_sqrt_checker;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [7:0]  radicand;
    logic [7:0]  root;
    logic [15:0] square;
    logic        pass;
    logic        valid_bit;
    logic        busy;
    logic [1:0]  state_dbg_o;

    int n_cmp;
    int n_fail;

    sqrt_checker dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .radicand    (radicand),
        .root        (root),
        .square      (square),
        .pass        (pass),
        .valid_bit   (valid_bit),
        .busy        (busy),
        .state_dbg_o (state_dbg_o)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic start_op(input logic [7:0] r, input logic [7:0] q);
        enable   = 1'b1;
        radicand = r;
        root     = q;
        @(negedge clock);
        enable   = 1'b0;
        radicand = 8'($urandom_range(0, 255));
        root     = 8'($urandom_range(0, 255));
    endtask

    task automatic run_check(input string tag, input logic [7:0] r, input logic [7:0] q,
                             input logic [15:0] exp_sq, input logic exp_pass);
        start_op(r, q);
        chk({tag, ".busy_e0"}, busy, 1'b1);
        chk({tag, ".valid_e0"}, valid_bit, 1'b0);
        tick(8);
        chk({tag, ".valid_e8"}, valid_bit, 1'b0);
        tick(1);
        chk({tag, ".valid_e9"}, valid_bit, 1'b1);
        chk({tag, ".busy_e9"}, busy, 1'b0);
        chk({tag, ".square"}, square, exp_sq);
        chk({tag, ".pass"}, pass, exp_pass);
    endtask

    initial begin
        int fr;
        n_cmp    = 0;
        n_fail   = 0;
        reset    = 1'b0;
        enable   = 1'b0;
        radicand = 8'd0;
        root     = 8'd0;

        tick(3);
        chk("rst.square", square, 16'd0);
        chk("rst.pass", pass, 1'b0);
        chk("rst.valid", valid_bit, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.state", state_dbg_o, 2'd0);
        reset = 1'b1;
        tick(2);

        run_check("exact121", 8'd121, 8'd11, 16'd121, 1'b1);
        run_check("upper143", 8'd143, 8'd11, 16'd121, 1'b1);
        run_check("small144", 8'd144, 8'd11, 16'd121, 1'b0);
        run_check("max255", 8'd0, 8'd255, 16'd65025, 1'b0);
        run_check("zero", 8'd0, 8'd0, 16'd0, 1'b1);

        // Pulse during CALC must be ignored.
        start_op(8'd255, 8'd15);
        tick(2);
        enable = 1'b1;
        root   = 8'd16;
        tick(1);
        enable = 1'b0;
        tick(6);
        chk("ign.valid", valid_bit, 1'b1);
        chk("ign.square", square, 16'd225);
        chk("ign.pass", pass, 1'b1);
        chk("ign.state", state_dbg_o, 2'd3);

        // Restart from DONE: valid drops at once, square held until recomputed.
        start_op(8'd100, 8'd10);
        chk("b2b.valid_drop", valid_bit, 1'b0);
        chk("b2b.square_hold", square, 16'd225);
        chk("b2b.busy", busy, 1'b1);
        tick(8);
        chk("b2b.valid_e8", valid_bit, 1'b0);
        tick(1);
        chk("b2b.valid_e9", valid_bit, 1'b1);
        chk("b2b.square", square, 16'd100);
        chk("b2b.pass", pass, 1'b1);

        // Asynchronous reset just after E4 of a run.
        start_op(8'd200, 8'd14);
        tick(3);
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("arst.square", square, 16'd0);
        chk("arst.pass", pass, 1'b0);
        chk("arst.valid", valid_bit, 1'b0);
        chk("arst.busy", busy, 1'b0);
        chk("arst.state", state_dbg_o, 2'd0);
        @(negedge clock);
        reset = 1'b1;
        tick(12);
        chk("post_rst.valid", valid_bit, 1'b0);
        chk("post_rst.busy", busy, 1'b0);
        chk("post_rst.state", state_dbg_o, 2'd0);
        run_check("after_rst", 8'd16, 8'd4, 16'd16, 1'b1);

        // Sweep: floor root passes, neighbours fail.
        for (int r = 0; r < 256; r++) begin
            fr = 0;
            while ((fr + 1) * (fr + 1) <= r) fr++;
            run_check($sformatf("sw%0d.root", r), 8'(r), 8'(fr), 16'(fr * fr), 1'b1);
            run_check($sformatf("sw%0d.plus", r), 8'(r), 8'(fr + 1), 16'((fr + 1) * (fr + 1)), 1'b0);
            if (fr > 0) begin
                run_check($sformatf("sw%0d.minus", r), 8'(r), 8'(fr - 1), 16'((fr - 1) * (fr - 1)), 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sqrt_checker.md
# sqrt_checker

Sequential verifier for the square-root datapath: takes a radicand and a candidate root, squares the root with an iterative shift-add multiplier, and reports whether the root is the exact integer floor square root of the radicand. It is the reverse direction of the square-root unit. It sits beside the square-root unit in the top level, is started by the same one-cycle pulse from the keypress conditioner, and drives a pass/fail indicator plus the 16-bit square for display.

## Interface
- No parameters; widths are fixed (8-bit operands, 16-bit square).
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clock`  input  1  system clock (CLOCK_40 at top level); all state changes on rising edge.
- `reset`  input  1  asynchronous, active-low; clears all state immediately.
- `enable`  input  1  start pulse, one cycle wide, synchronous to `clock`.
- `radicand`  input  8  value under test; sampled only on an accepted `enable`.
- `root`  input  8  candidate root; sampled only on an accepted `enable`.
- `square`  output  16  root × root; valid while `valid_bit`=1.
- `pass`  output  1  1 when root² ≤ radicand < (root+1)²; valid while `valid_bit`=1.
- `valid_bit`  output  1  result valid; held until the next accepted start or reset.
- `busy`  output  1  1 in CALC and CHECK.

## Operation
- States: IDLE, CALC, CHECK, DONE.
- IDLE: `enable`=1 latches `radicand`→rad_q and `root`→mcand (16-bit, zero-extended) and mplier (8-bit). Clears acc (16-bit) and cnt (4-bit). Go to CALC.
- CALC, once per cycle:
  - If mplier[0]=1, acc ← acc + mcand. Add is 16-bit and cannot overflow, since 255² = 65025.
  - mcand ← mcand << 1; mplier ← mplier >> 1; cnt ← cnt + 1.
  - After the 8th iteration (cnt was 7), go to CHECK.
  - No early exit: the cycle count is constant whatever the data.
- CHECK, one cycle:
  - Compute upper = acc + (root_q << 1) + 1 at 17 bits, where root_q is the latched root.
  - pass ← (acc ≤ {8'b0,rad_q}) && (upper > {9'b0,rad_q}).
  - square ← acc; valid_bit ← 1. Go to DONE.
- DONE:
  - Outputs hold.
  - `enable`=1 re-latches the inputs, clears `valid_bit`, keeps `square`/`pass` at their old values (don't-care while invalid), and goes to CALC.
- `enable` in CALC or CHECK is ignored; no queuing.
- Inputs changing while not sampled have no effect.
- `reset` low in any state:
  - Outputs and all internal registers go to 0 immediately; state goes to IDLE.
  - On release, the block waits for a fresh `enable`.

## Timing
- Reset values: `square`=0, `pass`=0, `valid_bit`=0, `busy`=0.
- Latency: `enable` sampled at edge E0.
  - CALC occupies edges E1..E8; CHECK is at E9.
  - `valid_bit`, `square` and `pass` update at E9, 9 cycles after acceptance.
  - The next start is accepted no earlier than E10.
- `busy` is 1 from after E0 until after E9; it is 0 in IDLE and DONE.
- `valid_bit` falls on the edge that accepts a new start from DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `enable` held high for several cycles: only the first edge in IDLE or DONE starts a run. A high level still present when DONE is reached restarts the block, so upstream must deliver true pulses.

## Test plan
- Exact square: radicand=121, root=11 → at E9, square=121, pass=1, valid_bit=1, busy=0.
- Upper boundary: radicand=143, root=11 → square=121, pass=1. Then radicand=144, root=11 → pass=0 (root too small).
- Root too large and maximum width: radicand=0, root=255 → square=65025 (0xFE01), pass=0, no overflow. Also radicand=0, root=0 → square=0, pass=1.
- Back-to-back runs and ignored pulses:
  - Start radicand=255, root=15 (pass=1).
  - Pulse `enable` at E3 with root=16: ignored, result still 225/pass=1.
  - New pulse in DONE: valid_bit drops on the next edge, rises 9 cycles later.
- Reset mid-operation: assert `reset`=0 at E4 of a run → all outputs 0 asynchronously, before the next edge.
  - After release, the block stays IDLE with no `valid_bit`.
  - A new start with radicand=16, root=4 → square=16, pass=1.
- Sweep: for every radicand 0..255, drive root=floor(√radicand) → pass=1. Drive root+1 and, where root>0, root−1 → pass=0.
